mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the processor data-memory bus: same write-enable/address/write-data/read-data signal set the core drives toward data memory, answering the core's initiator side.
- Accepts byte writes into a transmit FIFO and serialises them as 8N1 UART frames on a single output pin.
- Provides status and baud-divisor registers readable in the same cycle, as the single-cycle core requires.
- The top level muxes its read data against data memory using the sel output.

Parameters:
- BASE_ADDR, 32'h0000_1000, 16-byte-aligned base of the register window.
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, ≥2.
- DEFAULT_DIV, 16'd867, reset value of DIVISOR; clocks per bit = DIVISOR+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_mem_write_enable  input  1  bus write strobe.
- data_mem_address  input  32  bus byte address.
- data_mem_write_data  input  32  bus write data.
- data_mem_read_data  output  32  combinational read data; 0 when not selected.
- sel  output  1  combinational; 1 when address[31:4] == BASE_ADDR[31:4].
- uart_tx  output  1  registered serial line; idle high.

Behaviour:
- Register map, word offset address[3:2]:
  - 0x0 TXDATA: write pushes write_data[7:0]; reads 0.
  - 0x4 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow; bits 31:4 = 0. Writing with bit3=1 clears overflow; other bits are ignored.
  - 0x8 DIVISOR: R/W, bits 15:0; upper bits read 0 and are ignored on write.
  - 0xC: reserved; reads 0, writes ignored.
- Writes take effect at the rising edge where sel and write_enable are both 1.
- Reads are purely combinational from current state.
- Reset (async assert, any state, including mid-frame):
  - uart_tx=1, state IDLE, FIFO empty, overflow=0, DIVISOR=DEFAULT_DIV, all counters 0.
  - Deassertion is synchronised internally (2-flop) before the FSM leaves IDLE.
- FIFO push/full rules:
  - A TXDATA write when full with no pop that edge: byte dropped, overflow set (sticky).
  - A TXDATA write when full with a simultaneous pop: the write is accepted.
  - An overflow-clear write in the same edge as a new overflow: the set wins.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty at an edge, pop the head into an 8-bit shifter, latch DIVISOR into the bit timer, drive uart_tx=0, go to START.
  - START, DATA, STOP each hold one bit for latched_div+1 cycles. A DIVISOR write mid-frame affects the next frame only.
  - DATA: 8 bits, LSB first; bit counter 0..7.
  - STOP: uart_tx=1. At the end of STOP, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency:
  - TXDATA write at edge E with FSM idle → start bit begins at edge E+1.
  - A frame lasts exactly 10*(latched_div+1) cycles.
- DIVISOR=0 is legal: 1 clock per bit.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty are derived from the MSB comparison.

Decomposition:
- Package mmio_uart_pkg:
  - register offset constants (TXDATA_OFS, STATUS_OFS, DIVISOR_OFS);
  - STATUS bit index constants;
  - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}.
- One sub-module: sync_fifo (parameterised width/depth; push, pop, full, empty, count).
- Address decode, register file and FSM stay in mmio_uart_tx.

Test Plan:
1. Reset mid-frame: pull reset low during DATA → uart_tx=1 immediately (before the next edge). After release: STATUS reads 0x2 and DIVISOR reads 867.
2. DIVISOR=3, write 0xA5 to BASE+0 → starting the next edge, uart_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). STATUS busy=1 during the frame and 0 afterwards.
3. DIVISOR=0, six TXDATA writes on consecutive cycles (0x01..0x06):
   - STATUS then reads 0xD (full, busy, overflow).
   - 0x01..0x05 are transmitted back-to-back with no idle between stop and start bits; 0x06 never appears.
   - Writing 0x8 to STATUS → overflow reads 0.
4. FIFO full, with a TXDATA write landing on the exact edge the FSM pops at the end of STOP → byte accepted, overflow stays 0, and all bytes are transmitted.
5. DIVISOR rewritten 3→7 during a frame → current frame keeps 4 cycles/bit; the next frame uses 8 cycles/bit.
6. Address decode:
   - Read BASE+0xC and BASE+0x0 → 0 with sel=1.
   - Read BASE+0x10 → sel=0, read_data=0.
   - Write BASE+0x10 → no FIFO push.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: register offsets, STATUS bit positions and the transmitter FSM states.
package mmio_uart_pkg;
  localparam logic [1:0] TXDATA_OFS  = 2'd0;
  localparam logic [1:0] STATUS_OFS  = 2'd1;
  localparam logic [1:0] DIVISOR_OFS = 2'd2;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; pointers carry an extra wrap bit so full/empty need no counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= wdata;
  end
  assign rdata = mem[rd_q[AW-1:0]];
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = wr_q == rd_q;
  assign count = wr_q - rd_q;
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 UART transmitter with TX FIFO, STATUS and baud DIVISOR registers.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_mem_write_enable,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_write_data,
  output logic [31:0] data_mem_read_data,
  output logic        sel,
  output logic        uart_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  tx_state_t state_q, state_d;
  logic [15:0] div_q, div_d, bdiv_q, bdiv_d, timer_q, timer_d;
  logic [7:0] shift_q, shift_d, fifo_head;
  logic [2:0] bit_q, bit_d;
  logic [1:0] sync_q, sync_d, ofs;
  logic tx_q, tx_d, ovf_q, ovf_d;
  logic fifo_full, fifo_empty, pop, push, wr, wr_tx, have_data, tick, unused_ok;
  logic [AW:0] fifo_count;
  logic [31:0] status;
  assign sel       = data_mem_address[31:4] == BASE_ADDR[31:4];
  assign ofs       = data_mem_address[3:2];
  assign wr        = sel && data_mem_write_enable;
  assign wr_tx     = wr && ofs == TXDATA_OFS;
  assign have_data = fifo_count != '0;
  assign tick      = timer_q == '0;
  // IDLE may only start once reset release has passed through the synchroniser
  assign pop       = have_data && ((state_q == IDLE && sync_q[1]) || (state_q == STOP && tick));
  assign push      = wr_tx && (!fifo_full || pop);
  assign uart_tx   = tx_q;
  assign unused_ok = ^{data_mem_address[1:0], data_mem_write_data[31:16]};
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(reset), .push(push), .pop(pop), .wdata(data_mem_write_data[7:0]),
    .rdata(fifo_head), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  always_comb begin
    status = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = state_q != IDLE;
    status[ST_OVF]   = ovf_q;
    data_mem_read_data = !sel ? '0 : ofs == STATUS_OFS ? status : ofs == DIVISOR_OFS ? {16'd0, div_q} : '0;
  end
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
    div_d  = (wr && ofs == DIVISOR_OFS) ? data_mem_write_data[15:0] : div_q;
    ovf_d  = (wr_tx && fifo_full && !pop) ? 1'b1 :
             (wr && ofs == STATUS_OFS && data_mem_write_data[ST_OVF]) ? 1'b0 : ovf_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pop) state_d = START;
      START: if (tick) state_d = DATA;
      DATA:  if (tick && bit_q == 3'd7) state_d = STOP;
      STOP:  if (tick) state_d = pop ? START : IDLE;
    endcase
  end
  // divisor is latched per frame so mid-frame DIVISOR writes only affect the next frame
  always_comb begin
    bdiv_d  = pop ? div_q : bdiv_q;
    timer_d = pop ? div_q : state_q == IDLE ? '0 : tick ? bdiv_q : timer_q - 16'd1;
    shift_d = pop ? fifo_head : (state_q == DATA && tick) ? shift_q >> 1 : shift_q;
    bit_d   = state_q == DATA ? bit_q + 3'(tick) : '0;
    tx_d    = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      div_q   <= DEFAULT_DIV;
      ovf_q   <= 1'b0;
      bdiv_q  <= '0;
      timer_q <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
      bdiv_q  <= bdiv_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end
endmodule
